// File: rtl/hidden_cpu_feeder_pkg.sv
// -----------------------------------------------------------------------------
// hidden_cpu_feeder_pkg
//   Shared definitions for the tile-CPU feeder.
//   - feeder_state_e : controller states
//   - CPU_*_BIT      : bit positions on the CPU io_in pin bus
//   - cpu_pins()     : packs clock, reset and instruction into a pin word
// -----------------------------------------------------------------------------
package hidden_cpu_feeder_pkg;

   localparam int INSTR_W       = 6;
   localparam int PIN_W         = 8;

   localparam int CPU_CLK_BIT   = 0;
   localparam int CPU_RST_BIT   = 1;
   localparam int CPU_INSTR_LSB = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CPURST,
      ST_RUN_SETUP,
      ST_RUN_HIGH,
      ST_RUN_CAPT,
      ST_DONE
   } feeder_state_e;

   function automatic logic [PIN_W-1:0] cpu_pins(input logic               clk_bit,
                                                  input logic               rst_bit,
                                                  input logic [INSTR_W-1:0] instr);
      logic [PIN_W-1:0] pins;
      pins                                = '0;
      pins[CPU_CLK_BIT]                   = clk_bit;
      pins[CPU_RST_BIT]                   = rst_bit;
      pins[CPU_INSTR_LSB +: INSTR_W]      = instr;
      return pins;
   endfunction

endpackage

// File: rtl/hidden_cpu_feeder_prog_buf.sv
// -----------------------------------------------------------------------------
// feeder_prog_buf
//   DEPTH x 6-bit program store: one synchronous write port, one asynchronous
//   read port.
//   Ports:
//     clk      in  block clock
//     we_i     in  write enable
//     waddr_i  in  write address
//     wdata_i  in  write data (instruction)
//     raddr_i  in  read address
//     rdata_o  out read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module feeder_prog_buf
   import hidden_cpu_feeder_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [INSTR_W-1:0] rdata_o
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   // NOTE: storage is deliberately not reset; prog_len alone decides which
   // entries are meaningful, so a reset would only cost a reset tree.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hidden_cpu_feeder.sv
// -----------------------------------------------------------------------------
// hidden_cpu_feeder
//   Buffers a short program of 6-bit instructions, then steps an external
//   8-bit tile CPU through it by driving its io_in pins (bit0 clock, bit1
//   reset, bits[7:2] instruction), one instruction per generated CPU clock.
//   The CPU's io_out is sampled after each instruction and returned over a
//   valid/ready result port.
//   Ports:
//     clk, rst                 block clock, async active-high reset
//     clear                    empty the program buffer (idle only)
//     load_valid/ready/data    program load stream
//     start                    run the buffered program
//     busy, done               run in progress / end-of-run pulse
//     prog_len                 number of buffered instructions
//     res_valid/ready/data/index  per-instruction CPU output sample
//     cpu_io_in                pins driven into the CPU (all registered)
//     cpu_io_out               pins sampled from the CPU
// -----------------------------------------------------------------------------
module hidden_cpu_feeder
   import hidden_cpu_feeder_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int RST_PULSES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_ready,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W:0]    prog_len,
   output logic               res_valid,
   output logic [PIN_W-1:0]   res_data,
   output logic [ADDR_W-1:0]  res_index,
   input  logic               res_ready,
   output logic [PIN_W-1:0]   cpu_io_in,
   input  logic [PIN_W-1:0]   cpu_io_out
);

   // One counter step per CPU-reset half period (low, high, low, high, ...).
   localparam int                    RST_CNT_W = (2 * RST_PULSES > 1) ? $clog2(2 * RST_PULSES) : 1;
   localparam logic [RST_CNT_W-1:0]  RST_LAST  = RST_CNT_W'(2 * RST_PULSES - 1);
   localparam logic [ADDR_W:0]       FULL_LEN  = (ADDR_W + 1)'(DEPTH);

   localparam logic [PIN_W-1:0]      PINS_IN_RESET = 8'b0000_0010;
   localparam logic [PIN_W-1:0]      PINS_IDLE     = 8'b0000_0000;

   feeder_state_e        state_q,     state_d;
   logic [ADDR_W:0]      prog_len_q,  prog_len_d;
   logic [ADDR_W-1:0]    idx_q,       idx_d;
   logic [RST_CNT_W-1:0] rst_cnt_q,   rst_cnt_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 res_valid_q, res_valid_d;
   logic [PIN_W-1:0]     res_data_q,  res_data_d;
   logic [ADDR_W-1:0]    res_index_q, res_index_d;
   logic [PIN_W-1:0]     cpu_io_q,    cpu_io_d;
   logic                 load_ready_q, load_ready_d;

   logic                 buf_we;
   logic [ADDR_W-1:0]    buf_raddr;
   logic [INSTR_W-1:0]   buf_rdata;
   logic                 load_beat;
   logic                 last_instr;

   feeder_prog_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (prog_len_q[ADDR_W-1:0]),
      .wdata_i (load_data),
      .raddr_i (buf_raddr),
      .rdata_o (buf_rdata)
   );

   // The buffer is read one step ahead: entry 0 while leaving CPU reset, the
   // following entry while waiting for the result handshake. This keeps the
   // pin register loadable straight from the RAM without a combinational loop.
   assign buf_raddr  = (state_q == ST_RUN_CAPT) ? idx_q + 1'b1 : '0;

   assign load_beat  = load_valid && load_ready_q;
   assign last_instr = (({1'b0, idx_q} + 1'b1) == prog_len_q);

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      prog_len_d  = prog_len_q;
      idx_d       = idx_q;
      rst_cnt_d   = rst_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_index_d = res_index_q;
      cpu_io_d    = cpu_io_q;
      buf_we      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (clear) begin
               prog_len_d = '0;
            end else if (load_beat) begin
               buf_we     = 1'b1;
               prog_len_d = prog_len_q + 1'b1;
            end else if (start) begin
               busy_d = 1'b1;
               if (prog_len_q == '0) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  cpu_io_d = PINS_IDLE;
               end else begin
                  state_d   = ST_CPURST;
                  rst_cnt_d = '0;
                  cpu_io_d  = cpu_pins(1'b0, 1'b1, '0);
               end
            end
         end

         ST_CPURST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d  = ST_RUN_SETUP;
               idx_d    = '0;
               cpu_io_d = cpu_pins(1'b0, 1'b0, buf_rdata);
            end else begin
               // Even count = clock low, odd count = clock high.
               rst_cnt_d = rst_cnt_q + 1'b1;
               cpu_io_d  = cpu_pins(~rst_cnt_q[0], 1'b1, '0);
            end
         end

         ST_RUN_SETUP: begin
            state_d               = ST_RUN_HIGH;
            cpu_io_d[CPU_CLK_BIT] = 1'b1;
         end

         ST_RUN_HIGH: begin
            // The CPU committed on the rising edge that opened this cycle, so
            // its io_out is settled by the end of it.
            state_d               = ST_RUN_CAPT;
            cpu_io_d[CPU_CLK_BIT] = 1'b0;
            res_data_d            = cpu_io_out;
            res_index_d           = idx_q;
            res_valid_d           = 1'b1;
         end

         ST_RUN_CAPT: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               if (last_instr) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  cpu_io_d = PINS_IDLE;
               end else begin
                  state_d  = ST_RUN_SETUP;
                  idx_d    = idx_q + 1'b1;
                  cpu_io_d = cpu_pins(1'b0, 1'b0, buf_rdata);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            cpu_io_d = PINS_IN_RESET;
         end
      endcase

      load_ready_d = (state_d == ST_IDLE) && (prog_len_d < FULL_LEN);
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   // NOTE: non-blocking assignments make every register sample the values of
   // the previous cycle, independent of statement order in this block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prog_len_q   <= '0;
         idx_q        <= '0;
         rst_cnt_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_index_q  <= '0;
         cpu_io_q     <= PINS_IN_RESET;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         prog_len_q   <= prog_len_d;
         idx_q        <= idx_d;
         rst_cnt_q    <= rst_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_index_q  <= res_index_d;
         cpu_io_q     <= cpu_io_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign load_ready = load_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign prog_len   = prog_len_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_index  = res_index_q;
   assign cpu_io_in  = cpu_io_q;

endmodule
